// File: rtl/stack_queue_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stack_queue_buffer
// Description : Parametrised LIFO/FIFO word store with a mode lock,
//               simultaneous push/pop, flush, an occupancy count and
//               sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_queue_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stackQueue,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              mode,
  output logic              overflow,
  output logic              underflow,
  output logic              mode_err
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);

  // Storage: one write port, one synchronous read port, no reset
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_mode;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_mode_err;

  logic              w_empty;
  logic              w_full;
  logic              w_mode_eff;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_push_rej;
  logic              w_pop_rej;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_cnt_idx;
  logic [PTR_W-1:0]  w_top_idx;
  logic [PTR_W-1:0]  w_wr_addr;
  logic [PTR_W-1:0]  w_rd_addr;
  logic [PTR_W-1:0]  w_wr_ptr_inc;
  logic [PTR_W-1:0]  w_rd_ptr_inc;
  logic [CNT_W-1:0]  w_count_next;

  // Occupancy status, operation qualification and the mode in force this cycle
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == c_CNT_FULL);
    // While empty the requested mode applies immediately, so a push in the
    // same cycle as a mode change already lands in the new organisation.
    w_mode_eff = w_empty ? stackQueue : r_mode;
    w_do_pop   = pop  && !flush && !w_empty;
    // A push into a full store is fine when a pop frees a slot the same cycle
    w_do_push  = push && !flush && (!w_full || w_do_pop);
    w_push_rej = push && !flush && !w_do_push;
    w_pop_rej  = pop  && !flush && w_empty;
    w_wr_en    = w_do_push && !rst;
  end

  // Address generation for both organisations
  always_comb begin
    // count <= DEPTH <= 2**PTR_W, so the low bits minus one give count-1
    // even when count == 2**PTR_W.
    w_cnt_idx    = r_count[PTR_W-1:0];
    w_top_idx    = w_cnt_idx - c_PTR_ONE;
    w_wr_ptr_inc = (r_wr_ptr == c_PTR_LAST) ? '0 : (r_wr_ptr + c_PTR_ONE);
    w_rd_ptr_inc = (r_rd_ptr == c_PTR_LAST) ? '0 : (r_rd_ptr + c_PTR_ONE);
    if (w_mode_eff) begin
      // Stack: a push+pop overwrites the word being popped (top swap)
      w_wr_addr = w_do_pop ? w_top_idx : w_cnt_idx;
      w_rd_addr = w_top_idx;
    end else begin
      w_wr_addr = r_wr_ptr;
      w_rd_addr = r_rd_ptr;
    end
  end

  // Next occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + c_CNT_ONE;
      2'b01:   w_count_next = r_count - c_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Memory write port; read-before-write on the swap comes from NBA ordering
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= data_in;
    end
  end

  // Occupancy and queue pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_mode_eff) begin
        // Stack indexing uses count only; pointers sit at 0 ready for queue use
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= w_wr_ptr_inc;
        if (w_do_pop)  r_rd_ptr <= w_rd_ptr_inc;
      end
    end
  end

  // Read data register and its one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_do_pop;
      if (w_do_pop) begin
        r_data_out <= r_mem[w_rd_addr];
      end
    end
  end

  // Mode lock and sticky error flags (cleared only by reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= stackQueue;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_mode_err  <= 1'b0;
    end else begin
      r_mode <= w_mode_eff;
      if (!w_empty && (stackQueue != r_mode)) r_mode_err <= 1'b1;
      if (w_push_rej) r_overflow  <= 1'b1;
      if (w_pop_rej)  r_underflow <= 1'b1;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign count      = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign mode       = r_mode;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign mode_err   = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_stack_queue_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_queue_buffer
// Description : Bench for stack_queue_buffer at DEPTH=32 and DEPTH=5, with a
//               behavioural model and a scoreboard of expected popped words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_queue_buffer;

  logic        clk = 1'b0;
  logic        rst, sq, push, pop, flush;
  logic [15:0] din;

  logic [15:0] d32_dout; logic d32_dv; logic [5:0] d32_count;
  logic        d32_empty, d32_full, d32_mode, d32_ovf, d32_unf, d32_merr;
  logic [15:0] d5_dout;  logic d5_dv;  logic [2:0] d5_count;
  logic        d5_empty, d5_full, d5_mode, d5_ovf, d5_unf, d5_merr;

  always #5 clk = ~clk;

  stack_queue_buffer #(.DATA_W(16), .DEPTH(32)) dut32 (
    .clk(clk), .rst(rst), .stackQueue(sq), .push(push), .pop(pop), .flush(flush),
    .data_in(din), .data_out(d32_dout), .data_valid(d32_dv), .count(d32_count),
    .empty(d32_empty), .full(d32_full), .mode(d32_mode), .overflow(d32_ovf),
    .underflow(d32_unf), .mode_err(d32_merr));

  stack_queue_buffer #(.DATA_W(16), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .stackQueue(sq), .push(push), .pop(pop), .flush(flush),
    .data_in(din), .data_out(d5_dout), .data_valid(d5_dv), .count(d5_count),
    .empty(d5_empty), .full(d5_full), .mode(d5_mode), .overflow(d5_ovf),
    .underflow(d5_unf), .mode_err(d5_merr));

  // Observed outputs of the instance under test
  bit          sel5;
  logic [15:0] o_dout;
  logic        o_dv, o_empty, o_full, o_mode, o_ovf, o_unf, o_merr;
  int          o_count;

  always_comb begin
    o_dout  = sel5 ? d5_dout  : d32_dout;
    o_dv    = sel5 ? d5_dv    : d32_dv;
    o_count = sel5 ? int'(d5_count) : int'(d32_count);
    o_empty = sel5 ? d5_empty : d32_empty;
    o_full  = sel5 ? d5_full  : d32_full;
    o_mode  = sel5 ? d5_mode  : d32_mode;
    o_ovf   = sel5 ? d5_ovf   : d32_ovf;
    o_unf   = sel5 ? d5_unf   : d32_unf;
    o_merr  = sel5 ? d5_merr  : d32_merr;
  end

  // Model state and scoreboard
  logic [15:0] mdl[$];
  logic [15:0] exp_q[$];
  logic        m_mode, m_ovf, m_unf, m_err;
  logic [15:0] m_dout;
  int          m_depth;
  int          checks = 0;
  int          errors = 0;

  // Scoreboard: every data_valid pulse must match the oldest expected word
  always @(posedge clk) begin
    logic [15:0] e;
    #2;
    if (o_dv === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: got data_out=%h, no pop outstanding", o_dout);
      end else begin
        e = exp_q.pop_front();
        if (o_dout !== e) begin
          errors++;
          $display("FAIL sb_data: got %h expected %h", o_dout, e);
        end
      end
    end
  end

  task automatic apply_reset(input int n, input logic sqv, input logic busy);
    rst = 1'b1; sq = sqv; push = busy; pop = busy; flush = 1'b0; din = 16'h0099;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    mdl.delete(); exp_q.delete();
    m_mode = sqv; m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0; m_dout = '0;
    m_depth = sel5 ? 5 : 32;
  endtask

  // One clock of stimulus; updates the model and queues expected pop data
  task automatic do_op(input logic p, input logic q, input logic f, input logic [15:0] d);
    logic eff, popok, pushok;
    logic [15:0] v;
    push = p; pop = q; flush = f; din = d;
    eff = (mdl.size() == 0) ? sq : m_mode;
    if (mdl.size() != 0 && sq != m_mode) m_err = 1'b1;
    m_mode = eff;
    if (f) begin
      mdl.delete();
    end else begin
      popok  = q && (mdl.size() > 0);
      pushok = p && ((mdl.size() < m_depth) || popok);
      if (popok) begin
        if (eff) begin v = mdl[$]; void'(mdl.pop_back()); end
        else     begin v = mdl[0]; void'(mdl.pop_front()); end
        exp_q.push_back(v);
        m_dout = v;
      end
      if (pushok) mdl.push_back(d);
      if (p && !pushok) m_ovf = 1'b1;
      if (q && !popok)  m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    sel5 = 1'b0;
    apply_reset(2, 1'b1, 1'b0);
    checks++; if (o_count !== 0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b expected 10", o_empty, o_full); end
    checks++; if (o_dout !== 16'h0000 || o_dv !== 1'b0) begin errors++; $display("FAIL reset_data: got %h/%b expected 0000/0", o_dout, o_dv); end
    checks++; if ({o_ovf, o_unf, o_merr} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {o_ovf, o_unf, o_merr}); end
    checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL reset_mode: got %b expected 1", o_mode); end
  endtask

  task automatic test_stack_fill;
    for (int i = 1; i <= 32; i++) begin
      do_op(1'b1, 1'b0, 1'b0, 16'(i));
      checks++; if (o_count !== mdl.size()) begin errors++; $display("FAIL fill_count: got %0d expected %0d", o_count, mdl.size()); end
    end
    checks++; if (o_full !== 1'b1 || o_count !== 32) begin errors++; $display("FAIL fill_full: got full=%b count=%0d expected 1/32", o_full, o_count); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b expected 0", o_ovf); end
    do_op(1'b1, 1'b0, 1'b0, 16'h0021);
    checks++; if (o_ovf !== 1'b1 || o_count !== 32) begin errors++; $display("FAIL push_full: got ovf=%b count=%0d expected 1/32", o_ovf, o_count); end
  endtask

  task automatic test_stack_drain;
    for (int i = 0; i < 32; i++) begin
      do_op(1'b0, 1'b1, 1'b0, 16'h0000);
      checks++; if (o_dv !== 1'b1 || o_dout !== 16'(32 - i)) begin errors++; $display("FAIL drain_word: got %b/%h expected 1/%h", o_dv, o_dout, 16'(32 - i)); end
    end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", o_empty); end
    do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (o_unf !== 1'b1 || o_dv !== 1'b0) begin errors++; $display("FAIL pop_empty: got unf=%b dv=%b expected 1/0", o_unf, o_dv); end
    checks++; if (o_dout !== 16'h0001) begin errors++; $display("FAIL pop_empty_hold: got %h expected 0001", o_dout); end
    #2;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_sb: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_queue_wrap;
    sel5 = 1'b1;
    apply_reset(1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) do_op(1'b1, 1'b0, 1'b0, 16'h00A0 + 16'(i));
    checks++; if (o_full !== 1'b1 || o_count !== 5) begin errors++; $display("FAIL q_full: got full=%b count=%0d expected 1/5", o_full, o_count); end
    repeat (3) do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (o_dout !== 16'h00A3 || o_count !== 2) begin errors++; $display("FAIL q_pop3: got %h/%0d expected 00A3/2", o_dout, o_count); end
    for (int i = 1; i <= 3; i++) do_op(1'b1, 1'b0, 1'b0, 16'h00B0 + 16'(i));
    checks++; if (o_count !== 5 || o_ovf !== 1'b0) begin errors++; $display("FAIL q_wrap_count: got %0d/%b expected 5/0", o_count, o_ovf); end
    repeat (5) do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (o_dout !== 16'h00B3 || o_empty !== 1'b1) begin errors++; $display("FAIL q_drain: got %h/%b expected 00B3/1", o_dout, o_empty); end
    #2;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL q_sb: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    sel5 = 1'b1;
    apply_reset(1, 1'b1, 1'b0);
    do_op(1'b1, 1'b0, 1'b0, 16'h0011);
    do_op(1'b1, 1'b0, 1'b0, 16'h0022);
    do_op(1'b1, 1'b1, 1'b0, 16'h0033);
    checks++; if (o_dout !== 16'h0022 || o_count !== 2) begin errors++; $display("FAIL swap: got %h/%0d expected 0022/2", o_dout, o_count); end
    do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (o_dout !== 16'h0033) begin errors++; $display("FAIL swap_next: got %h expected 0033", o_dout); end
    apply_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 1'b0, 16'h00C0 + 16'(i));
    do_op(1'b1, 1'b1, 1'b0, 16'h00C5);
    checks++; if (o_count !== 5 || o_ovf !== 1'b0 || o_dout !== 16'h00C0) begin errors++; $display("FAIL full_pp: got %0d/%b/%h expected 5/0/00C0", o_count, o_ovf, o_dout); end
    apply_reset(1, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, 1'b0, 16'h0044);
    checks++; if (o_count !== 1 || o_unf !== 1'b1 || o_dv !== 1'b0) begin errors++; $display("FAIL empty_pp: got %0d/%b/%b expected 1/1/0", o_count, o_unf, o_dv); end
    do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (o_dout !== 16'h0044) begin errors++; $display("FAIL empty_pp_word: got %h expected 0044", o_dout); end
  endtask

  task automatic test_mode_lock;
    sel5 = 1'b1;
    apply_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 1'b0, 16'h00D0 + 16'(i));
    do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    do_op(1'b1, 1'b0, 1'b0, 16'h00D3);
    sq = 1'b1;
    do_op(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++; if (o_mode !== 1'b0 || o_merr !== 1'b1 || o_count !== 3) begin errors++; $display("FAIL lock: got mode=%b err=%b count=%0d expected 0/1/3", o_mode, o_merr, o_count); end
    do_op(1'b1, 1'b1, 1'b1, 16'h00EE);
    checks++; if (o_count !== 0 || o_dv !== 1'b0 || o_dout !== m_dout) begin errors++; $display("FAIL flush: got %0d/%b/%h expected 0/0/%h", o_count, o_dv, o_dout, m_dout); end
    do_op(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++; if (o_mode !== 1'b1 || o_merr !== 1'b1) begin errors++; $display("FAIL follow: got mode=%b err=%b expected 1/1", o_mode, o_merr); end
    do_op(1'b1, 1'b0, 1'b0, 16'h00F1);
    do_op(1'b1, 1'b0, 1'b0, 16'h00F2);
    do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (o_dout !== 16'h00F2) begin errors++; $display("FAIL new_mode_lifo: got %h expected 00F2", o_dout); end
  endtask

  task automatic test_reset_midway;
    sel5 = 1'b0;
    apply_reset(1, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 1; i <= 5; i++) do_op(1'b1, 1'b0, 1'b0, 16'h0050 + 16'(i));
    do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    sq = 1'b1;
    do_op(1'b1, 1'b0, 1'b0, 16'h0056);
    sq = 1'b0;
    checks++; if (o_unf !== 1'b1 || o_merr !== 1'b1) begin errors++; $display("FAIL pre_reset_flags: got %b%b expected 11", o_unf, o_merr); end
    apply_reset(1, 1'b0, 1'b1);
    checks++; if (o_count !== 0 || o_empty !== 1'b1) begin errors++; $display("FAIL mid_reset_count: got %0d/%b expected 0/1", o_count, o_empty); end
    checks++; if ({o_ovf, o_unf, o_merr, o_dv} !== 4'b0000 || o_dout !== 16'h0000) begin errors++; $display("FAIL mid_reset_state: got %b/%h expected 0000/0000", {o_ovf, o_unf, o_merr, o_dv}, o_dout); end
    do_op(1'b1, 1'b0, 1'b0, 16'h0077);
    do_op(1'b1, 1'b0, 1'b0, 16'h0078);
    do_op(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++; if (o_dout !== 16'h0077) begin errors++; $display("FAIL mid_reset_index0: got %h expected 0077", o_dout); end
    #2;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_reset_sb: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; sq = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; din = '0; sel5 = 1'b0;
    test_reset();
    test_stack_fill();
    test_stack_drain();
    test_queue_wrap();
    test_back_to_back();
    test_mode_lock();
    test_reset_midway();
    repeat (2) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
